// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch unit.
package imem_pkg;

  typedef enum logic {CLEAR, RUN} fsm_t;

  localparam int FLT_MISALIGN = 0;
  localparam int FLT_RANGE    = 1;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_fetch_unit_ram.sv
// 1R1W synchronous RAM with a registered read port; a read and a write to the
// same word on the same edge return the old contents.
module imem_ram #(
  parameter  int WORD_W = 32,
  parameter  int DEPTH  = 64,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with registered fetch, stall hold, fault flags, program-load
// port and post-reset clear sweep. Define IMEM_PARITY_EN for per-word even parity.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter  int                DATA_W   = 32,
  parameter  int                DEPTH    = 64,
  parameter  logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_DEFAULT),
  localparam int                ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_pc,
  input  logic              if_stall,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [31:0]       if_pc_out,
  output logic [1:0]        if_fault,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
`ifdef IMEM_PARITY_EN
  output logic              if_perr,
`endif
  output logic              init_busy
);

`ifdef IMEM_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  fsm_t              state, state_nxt;
  logic [ADDR_W-1:0] sweep_cnt, sweep_cnt_nxt;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wword;
  logic [RAM_W-1:0]  ram_wdata;
  logic [RAM_W-1:0]  ram_rdata;
  logic [1:0]        flt;
  logic              fetch_go;
  logic              use_ram;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      sweep_cnt <= '0;
    end else begin
      state     <= state_nxt;
      sweep_cnt <= sweep_cnt_nxt;
    end
  end

  // The sweep owns the single write port until every word holds NOP_WORD.
  always_comb begin
    state_nxt     = state;
    sweep_cnt_nxt = sweep_cnt;
    ram_we        = 1'b0;
    ram_waddr     = ld_addr;
    ram_wword     = ld_data;
    ld_ack        = 1'b0;
    case (state)
      CLEAR: begin
        ram_we        = 1'b1;
        ram_waddr     = sweep_cnt;
        ram_wword     = NOP_WORD;
        sweep_cnt_nxt = sweep_cnt + 1'b1;
        if (sweep_cnt == ADDR_W'(DEPTH - 1)) state_nxt = RUN;
      end
      RUN: begin
        ram_we = ld_we;
        ld_ack = ld_we;
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign init_busy = (state == CLEAR);

`ifdef IMEM_PARITY_EN
  assign ram_wdata = {^ram_wword, ram_wword};
`else
  assign ram_wdata = ram_wword;
`endif

  always_comb begin
    flt               = '0;
    flt[FLT_MISALIGN] = |if_pc[1:0];
    flt[FLT_RANGE]    = |if_pc[31:ADDR_W+2];
  end

  assign fetch_go = if_req && !if_stall && (state == RUN);

  imem_ram #(
    .WORD_W (RAM_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (fetch_go),
    .raddr (if_pc[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  // Fetch stage: RAM output register plus these flags form the IF/ID-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid  <= 1'b0;
      if_pc_out <= '0;
      if_fault  <= '0;
      use_ram   <= 1'b0;
    end else if (!if_stall) begin
      if_valid <= fetch_go;
      if_fault <= fetch_go ? flt : 2'b00;
      use_ram  <= fetch_go && (flt == 2'b00);
      if (fetch_go) if_pc_out <= if_pc;
    end
  end

  assign if_instr = use_ram ? ram_rdata[DATA_W-1:0] : NOP_WORD;

`ifdef IMEM_PARITY_EN
  assign if_perr = use_ram && (^ram_rdata);
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Scoreboard bench for imem_fetch_unit; build with IMEM_PARITY_EN for the parity case.
module tb_imem_fetch_unit;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, if_req, if_stall, ld_we;
  logic [31:0] if_pc, ld_data;
  logic [5:0]  ld_addr;
  logic        if_valid, ld_ack, init_busy;
  logic [31:0] if_instr, if_pc_out;
  logic [1:0]  if_fault;
  logic        if_perr;

  imem_fetch_unit #(
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_pc     (if_pc),
    .if_stall  (if_stall),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc_out (if_pc_out),
    .if_fault  (if_fault),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_ack    (ld_ack),
`ifdef IMEM_PARITY_EN
    .if_perr   (if_perr),
`endif
    .init_busy (init_busy)
  );

`ifndef IMEM_PARITY_EN
  assign if_perr = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [1:0]  flt;
    logic        perr;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_last;
  logic [31:0] m_mem [DEPTH];
  logic        m_bad [DEPTH];
  logic        m_run;
  int          m_cnt;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run  = 1'b0;
    m_cnt  = 0;
    m_last = '{v: 1'b0, instr: NOP, pc: 32'h0, flt: 2'b00, perr: 1'b0};
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc", if_pc_out, 0);
    chk("rst_fault", if_fault, 0);
    chk("rst_busy", init_busy, 1);
  endtask

  // One clock: inputs must already be driven; predicts, then compares after the edge.
  task automatic step();
    exp_t e, got;
    logic [1:0] f;
    int idx;
    #1;
    chk("ld_ack", ld_ack, ld_we && m_run);
    @(posedge clk);
    if (if_stall) e = m_last;
    else if (if_req && m_run) begin
      f[0] = (if_pc[1:0] != 2'b00);
      f[1] = ((if_pc >> 2) >= DEPTH);
      idx  = int'(if_pc[7:2]);
      e.v     = 1'b1;
      e.pc    = if_pc;
      e.flt   = f;
      e.instr = (f != 2'b00) ? NOP : m_mem[idx];
      e.perr  = (f == 2'b00) && m_bad[idx];
    end else begin
      e = '{v: 1'b0, instr: NOP, pc: m_last.pc, flt: 2'b00, perr: 1'b0};
    end
    if (m_run) begin
      if (ld_we) begin
        m_mem[ld_addr] = ld_data;
        m_bad[ld_addr] = 1'b0;
      end
    end else begin
      m_mem[m_cnt] = NOP;
      m_bad[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == DEPTH) m_run = 1'b1;
    end
    m_last = e;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    chk("valid", if_valid, got.v);
    chk("busy", init_busy, !m_run);
    if (got.v) begin
      chk("instr", if_instr, got.instr);
      chk("pc_out", if_pc_out, got.pc);
      chk("fault", if_fault, got.flt);
`ifdef IMEM_PARITY_EN
      chk("perr", if_perr, got.perr);
`endif
    end
  endtask

  task automatic fetch(input logic [31:0] pc);
    if_req = 1'b1;
    if_pc  = pc;
    step();
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    if_req  = 1'b0;
    ld_we   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we = 1'b0;
  endtask

  task automatic sweep_and_count();
    int busy_len;
    busy_len = init_busy ? 1 : 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (!init_busy) break;
      step();
      if (init_busy) busy_len++;
    end
    chk("busy_len", busy_len, DEPTH);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_bad[i] = 1'b0;
    rst = 1'b0; if_req = 1'b0; if_pc = '0; if_stall = 1'b0;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;

    // Sweep with a fetch request held high throughout.
    if_req = 1'b1;
    if_pc  = 32'h0;
    sweep_and_count();

    load(6'd0, 32'h2010_000A);
    fetch(32'h0);
    load(6'd1, 32'h1111_0001);
    load(6'd2, 32'h2222_0002);
    fetch(32'h6);
    fetch(32'h100);
    fetch(32'h102);
    fetch(32'hFC);
    fetch(32'h8);
    if_req = 1'b0;
    step();

    // Stall hold while the PC keeps moving.
    fetch(32'h4);
    if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if_pc = 32'h8 + 32'(4 * i);
      if_req = (i != 1);
      step();
    end
    if_stall = 1'b0;
    fetch(32'h8);

    // Read-before-write on a same-cycle load and fetch.
    load(6'd5, 32'h5555_0005);
    ld_we = 1'b1; ld_addr = 6'd5; ld_data = 32'hA5A5_0005;
    fetch(32'h14);
    ld_we = 1'b0;
    fetch(32'h14);

`ifdef IMEM_PARITY_EN
    load(6'd7, 32'h7777_0007);
    dut.u_ram.mem[7][0] = ~dut.u_ram.mem[7][0];
    m_mem[7] = m_mem[7] ^ 32'h1;
    m_bad[7] = 1'b1;
    fetch(32'h1C);
    fetch(32'h0);
`endif

    // Reset mid-sweep, with a rejected load attempt during the sweep.
    if_req = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ld_we = (i == 10); ld_addr = 6'd3; ld_data = 32'hBAD0_0003;
      step();
    end
    ld_we = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_and_count();
    fetch(32'hC);
    fetch(32'h4);
    fetch(32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
